// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SRAM access arbiter.
package slc3_mem_pkg;

  // Largest supported number of extra strobe cycles (3-bit strobe counter).
  localparam int unsigned WaitCyclesMax = 7;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } port_id_t;

  // Round-robin partner of a requester.
  function automatic port_id_t other_port(input port_id_t p);
    return (p == CPU) ? DBG : CPU;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant selection with the last-grant register.
// Optional macro ARB_LOCK_EN adds lock_i, which keeps the CPU out while the
// debug port holds the last grant.
module mem_arb_rr
  import slc3_mem_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_cpu_i,
  input  logic req_dbg_i,
`ifdef ARB_LOCK_EN
  input  logic lock_i,
`endif
  input  logic take_i,
  output logic gnt_valid_o,
  output logic gnt_dbg_o
);

  port_id_t last_q, last_d;
  port_id_t gnt_id;
  logic     cpu_eligible;

  // Pick a winner from the current requests and the last grant.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id      = CPU;
`ifdef ARB_LOCK_EN
    cpu_eligible = req_cpu_i & ~(lock_i & (last_q == DBG));
`else
    cpu_eligible = req_cpu_i;
`endif
    if (cpu_eligible && req_dbg_i) begin
      gnt_valid_o = 1'b1;
      gnt_id      = other_port(last_q);
    end else if (cpu_eligible) begin
      gnt_valid_o = 1'b1;
      gnt_id      = CPU;
    end else if (req_dbg_i) begin
      gnt_valid_o = 1'b1;
      gnt_id      = DBG;
    end
    gnt_dbg_o = (gnt_id == DBG);
    last_d    = (take_i && gnt_valid_o) ? gnt_id : last_q;
  end

  // Last-grant register; DBG after reset so the CPU wins the first tie.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q <= DBG;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates CPU and debug requesters onto one asynchronous SRAM port.
// Each access: IDLE (grant + latch) -> READ/WRITE for WAIT_CYCLES+1 cycles
// -> DONE (one-cycle ack) -> IDLE. All SRAM strobes are active-low and
// registered. Define ARB_LOCK_EN to add the dbg_lock input.
module mem_access_arbiter
  import slc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
`ifdef ARB_LOCK_EN
  input  logic        dbg_lock,
`endif
  output logic        cpu_ack,
  output logic        dbg_ack,
  output logic [15:0] rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_drive,
  input  logic [15:0] mem_rdata,
  output logic        Mem_CE,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic        Mem_UB,
  output logic        Mem_LB
);

  // Out-of-range settings saturate at the counter's reach.
  localparam logic [2:0] WaitLast =
      (WAIT_CYCLES > WaitCyclesMax) ? 3'(WaitCyclesMax) : 3'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  port_id_t    owner_q, owner_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;

  logic ack_cpu_q, ack_cpu_d;
  logic ack_dbg_q, ack_dbg_d;
  logic ce_n_q, ce_n_d;
  logic oe_n_q, oe_n_d;
  logic we_n_q, we_n_d;
  logic drive_q, drive_d;

  logic     gnt_valid;
  logic     gnt_dbg;
  port_id_t gnt_id;

  assign gnt_id = port_id_t'(gnt_dbg);

  mem_arb_rr u_arb (
    .clk_i      (Clk),
    .reset_i    (Reset),
    .req_cpu_i  (cpu_req),
    .req_dbg_i  (dbg_req),
`ifdef ARB_LOCK_EN
    .lock_i     (dbg_lock),
`endif
    .take_i     (state_q == StIdle),
    .gnt_valid_o(gnt_valid),
    .gnt_dbg_o  (gnt_dbg)
  );

  // Next state: grant and latch in IDLE, count strobe cycles, capture read data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          owner_d = gnt_id;
          if (gnt_id == DBG) begin
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
          cnt_d   = '0;
          state_d = we_d ? StWrite : StRead;
        end
      end
      StRead, StWrite: begin
        if (cnt_q == WaitLast) begin
          cnt_d   = '0;
          state_d = StDone;
          if (state_q == StRead) begin
            rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Strobes and acks decoded from the next state so they leave a flop cleanly.
  always_comb begin
    ce_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    drive_d   = 1'b0;
    ack_cpu_d = 1'b0;
    ack_dbg_d = 1'b0;
    unique case (state_d)
      StRead: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      StWrite: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        drive_d = 1'b1;
      end
      StDone: begin
        ack_cpu_d = (owner_d == CPU);
        ack_dbg_d = (owner_d == DBG);
      end
      default: begin
      end
    endcase
  end

  // State and output registers; reset aborts any access without an ack.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      owner_q   <= CPU;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ack_cpu_q <= 1'b0;
      ack_dbg_q <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      drive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ack_cpu_q <= ack_cpu_d;
      ack_dbg_q <= ack_dbg_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      drive_q   <= drive_d;
    end
  end

  assign cpu_ack   = ack_cpu_q;
  assign dbg_ack   = ack_dbg_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_drive = drive_q;
  assign Mem_CE    = ce_n_q;
  assign Mem_OE    = oe_n_q;
  assign Mem_WE    = we_n_q;
  assign Mem_UB    = ce_n_q;
  assign Mem_LB    = ce_n_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: table of single accesses plus hand-written
// reset-abort, round-robin, zero-wait and (with ARB_LOCK_EN) lock sequences.
// Acks are checked against a scoreboard queue of expected completions.
module tb_mem_access_arbiter;

  typedef struct {
    bit          is_dbg;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_ack, dbg_ack, mem_drive;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;

  // Second instance with WAIT_CYCLES=0; only its CPU request is exercised.
  logic        cpu_req0, no_req;
  logic        cpu_ack0, dbg_ack0, mem_drive0;
  logic [15:0] rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic        Mem_CE0, Mem_OE0, Mem_WE0, Mem_UB0, Mem_LB0;

  logic [15:0] sram [256];
  logic        mem_init;

  int   checks = 0;
  int   failures = 0;
  vec_t sb[$];
  vec_t vecs [8];
  bit   prev_ack = 1'b0;

  always #5 Clk = ~Clk;

  mem_access_arbiter #(.WAIT_CYCLES(1)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
`ifdef ARB_LOCK_EN
    .dbg_lock(dbg_lock),
`endif
    .cpu_ack(cpu_ack), .dbg_ack(dbg_ack), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_drive(mem_drive),
    .mem_rdata(mem_rdata),
    .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB)
  );

  mem_access_arbiter #(.WAIT_CYCLES(0)) dut0 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req0), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dbg_req(no_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
`ifdef ARB_LOCK_EN
    .dbg_lock(dbg_lock),
`endif
    .cpu_ack(cpu_ack0), .dbg_ack(dbg_ack0), .rdata(rdata0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_drive(mem_drive0),
    .mem_rdata(mem_rdata0),
    .Mem_CE(Mem_CE0), .Mem_OE(Mem_OE0), .Mem_WE(Mem_WE0), .Mem_UB(Mem_UB0), .Mem_LB(Mem_LB0)
  );

  // SRAM model: 256 words, preset to 0x1234 ^ {i,i}, written by the main DUT only.
  always @(posedge Clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) sram[i] <= 16'h1234 ^ {i[7:0], i[7:0]};
    end else if (!Mem_CE && !Mem_WE && mem_drive) begin
      sram[mem_addr[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata  = sram[mem_addr[7:0]];
  assign mem_rdata0 = sram[mem_addr0[7:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack of the main DUT pops one expected completion.
  always @(negedge Clk) begin
    vec_t e;
    if (!Reset && (cpu_ack || dbg_ack)) begin
      check("single_ack_port", {31'd0, cpu_ack & dbg_ack}, 32'd0);
      check("ack_one_pulse", {31'd0, prev_ack}, 32'd0);
      check("ack_expected", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ack_port", {31'd0, dbg_ack}, {31'd0, e.is_dbg});
        if (!e.we) check("rdata", {16'd0, rdata}, {16'd0, e.exp_rdata});
      end
    end
    prev_ack = cpu_ack | dbg_ack;
  end

  task automatic drive(input vec_t v, input bit req);
    if (v.is_dbg) begin
      dbg_req = req; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
    end else begin
      cpu_req = req; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
  endtask

  // One access; the request is dropped and the inputs scrambled right after the grant.
  task automatic do_access(input vec_t v);
    int   n = 0, oe = 0, we = 0, bad = 0;
    vec_t junk;
    @(posedge Clk); #1;
    sb.push_back(v);
    drive(v, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(posedge Clk); #1;
      n++;
      if (!Mem_OE) oe++;
      if (!Mem_WE) begin
        we++;
        if (!mem_drive || mem_wdata !== v.wdata) bad++;
      end
      if (!Mem_CE && mem_addr !== v.addr) bad++;
      if (Mem_UB !== Mem_CE || Mem_LB !== Mem_CE) bad++;
      if (n == 1) begin
        junk = v; junk.we = ~v.we; junk.addr = ~v.addr; junk.wdata = ~v.wdata;
        drive(junk, 1'b0);
      end
      if (cpu_ack || dbg_ack) break;
    end
    check("latency", n, 3);
    check("oe_cycles", oe, v.we ? 0 : 2);
    check("we_cycles", we, v.we ? 2 : 0);
    check("bus_during_strobe", bad, 0);
    cpu_req = 1'b0; dbg_req = 1'b0;
  endtask

  // Hold both requests until n acks appear; returns cycle of the last ack.
  task automatic hold_both(input int n_acks, output int got, output int last_cyc);
    got = 0; last_cyc = 0;
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge Clk); #1;
      if (cpu_ack || dbg_ack) begin
        got++;
        last_cyc = k;
        if (got == n_acks) break;
      end
    end
  endtask

  initial begin
    int   n, oe, got, cyc;
    vec_t rc, rd;
    vecs[0] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234};
    vecs[1] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b1, 16'h00FF, 16'h0F0F, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h0F0F};
    vecs[5] = '{1'b1, 1'b0, 16'h0042, 16'h0000, 16'h5076};
    vecs[6] = '{1'b0, 1'b1, 16'h1042, 16'hA5A5, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 16'h2042, 16'h0000, 16'hA5A5};

    Reset = 1'b1; mem_init = 1'b1; no_req = 1'b0; dbg_lock = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_req0 = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    repeat (3) @(posedge Clk);
    #1 mem_init = 1'b0;
    check("reset_acks", {30'd0, cpu_ack, dbg_ack}, 32'd0);
    check("reset_rdata", {16'd0, rdata}, 32'd0);
    check("reset_drive", {31'd0, mem_drive}, 32'd0);
    check("reset_strobes", {27'd0, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB}, 32'h1F);
    Reset = 1'b0;

    for (int i = 0; i < 8; i++) do_access(vecs[i]);

    // Reset during READ: strobes released, no ack.
    @(posedge Clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0005; cpu_req = 1'b1;
    @(posedge Clk); #1;
    check("abort_in_read", {31'd0, Mem_OE}, 32'd0);
    Reset = 1'b1; cpu_req = 1'b0;
    @(posedge Clk); #1;
    check("abort_strobes", {27'd0, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB}, 32'h1F);
    check("abort_acks", {30'd0, cpu_ack, dbg_ack}, 32'd0);
    check("abort_drive", {31'd0, mem_drive}, 32'd0);
    Reset = 1'b0;
    n = 0;
    repeat (6) begin
      @(posedge Clk); #1;
      if (cpu_ack || dbg_ack || !Mem_CE) n++;
    end
    check("abort_stays_idle", n, 0);

    // Both held: CPU, DBG, CPU, DBG back to back, one ack every 4 cycles.
    rc = '{1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234};
    rd = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h0F0F};
    sb.push_back(rc); sb.push_back(rd); sb.push_back(rc); sb.push_back(rd);
    drive(rc, 1'b1); drive(rd, 1'b1);
    hold_both(4, got, cyc);
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("rr_ack_count", got, 4);
    check("rr_last_ack_cycle", cyc, 15);

    // WAIT_CYCLES=0 instance: one OE cycle, ack in the third cycle.
    @(posedge Clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h3000; cpu_req0 = 1'b1;
    n = 0; oe = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge Clk); #1;
      n++;
      if (!Mem_OE0) oe++;
      if (cpu_ack0) break;
    end
    cpu_req0 = 1'b0;
    check("w0_latency", n, 2);
    check("w0_oe_cycles", oe, 1);
    check("w0_rdata", {16'd0, rdata0}, 32'h1234);

`ifdef ARB_LOCK_EN
    // Lock held: DBG keeps winning; CPU only after the lock drops.
    @(posedge Clk); #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    dbg_lock = 1'b1;
    sb.push_back(rd); sb.push_back(rd); sb.push_back(rd);
    drive(rc, 1'b1); drive(rd, 1'b1);
    hold_both(3, got, cyc);
    check("lock_dbg_acks", got, 3);
    dbg_lock = 1'b0;
    sb.push_back(rc);
    hold_both(1, got, cyc);
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("lock_release_ack", got, 1);
`endif

    repeat (4) @(posedge Clk);
    #1 check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 The block SHALL have one parameter: WAIT_CYCLES, default 1, number of extra strobe cycles per SRAM access (legal range 0..7).
REQ-002 The block SHALL have port Clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, reset that is synchronous and active-high.
REQ-004 The block SHALL have ports cpu_req, cpu_we, input, 1 each: CPU access request (level, held until ack) and write select.
REQ-005 The block SHALL have ports cpu_addr, cpu_wdata, input, 16 each: CPU address and write data.
REQ-006 The block SHALL have ports dbg_req, dbg_we, input, 1 each, and dbg_addr, dbg_wdata, input, 16 each: debug/IO requester, same meaning as the CPU ports.
REQ-007 The block SHALL have ports cpu_ack, dbg_ack, output, 1 each: one-cycle completion pulse to the granted requester.
REQ-008 The block SHALL have port rdata, output, 16: registered read data, valid in the ack cycle and held until the next read capture.
REQ-009 The block SHALL have ports mem_addr, mem_wdata, output, 16 each: address and write data to SRAM; mem_drive, output, 1: data-bus drive enable.
REQ-010 The block SHALL have port mem_rdata, input, 16: SRAM read data.
REQ-011 The block SHALL have ports Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, output, 1 each, all active-low.

Function
REQ-012 The state machine SHALL have states IDLE, READ, WRITE, DONE.
REQ-013 In IDLE with at least one request, the block SHALL grant one requester and latch its addr, wdata and we into registers; it SHALL enter READ or WRITE on the next edge.
REQ-014 Arbitration SHALL be 2-way round-robin: on simultaneous requests, the requester not granted last wins; a lone request always wins.
REQ-015 READ and WRITE SHALL last WAIT_CYCLES+1 cycles, counted by a 3-bit strobe counter; then the state SHALL go to DONE.
REQ-016 In READ, Mem_OE SHALL be 0; mem_rdata SHALL be captured into rdata on the last READ cycle's edge.
REQ-017 In WRITE, Mem_WE and mem_drive SHALL be 1/0 per active-low and drive sense respectively: Mem_WE=0 and mem_drive=1; mem_wdata SHALL equal the latched data.
REQ-018 In DONE, the granted ack SHALL be 1 for exactly one cycle; the next state SHALL always be IDLE.
REQ-019 Access latency SHALL be WAIT_CYCLES+3 cycles from the request being sampled in IDLE to the ack cycle; with WAIT_CYCLES=1 that is 4 cycles.
REQ-020 If a request drops mid-access, the access SHALL still complete and ack SHALL still pulse; input changes after grant SHALL be ignored.
REQ-021 A requester holding req through ack SHALL be eligible again in the IDLE cycle after DONE.
REQ-022 Mem_CE, Mem_UB and Mem_LB SHALL be 0 in READ/WRITE and 1 otherwise; Mem_OE and Mem_WE SHALL be 1 outside their states.

Reset
REQ-023 While Reset=1 at an edge, the block SHALL go to state IDLE and set counter=0 and last_grant=DBG, so the CPU wins the first tie.
REQ-024 While Reset=1 at an edge, the block SHALL set acks=0, rdata=0 and mem_drive=0, and all Mem_* strobes to 1.
REQ-025 Reset mid-access SHALL abort the access without an ack.

Configuration
REQ-026 With ARB_LOCK_EN defined, an input dbg_lock (1 bit) SHALL exist; while it is 1 and the last grant was DBG, cpu_req SHALL NOT be granted.
REQ-027 Without ARB_LOCK_EN, the dbg_lock port SHALL be absent and arbitration SHALL be pure round-robin.

Structure
REQ-028 Package slc3_mem_pkg SHALL hold the state enum, the port_id_t typedef {CPU, DBG} and the WAIT_CYCLES maximum constant.
REQ-029 Grant selection SHALL be a sub-module mem_arb_rr (2-way round-robin, last_grant register inside).

Verification
REQ-030 CPU read, addr 0x3000, mem_rdata 0x1234, WAIT_CYCLES=1 -> Mem_OE=0 for 2 cycles; cpu_ack in cycle 4; rdata=0x1234.
REQ-031 DBG write, addr 0x0010, data 0xBEEF -> Mem_WE=0 and mem_drive=1 for 2 cycles with mem_addr=0x0010; dbg_ack one pulse.
REQ-032 Both requesters held high for 4 accesses -> grants CPU, DBG, CPU, DBG.
REQ-033 Reset asserted during a READ -> next cycle IDLE, all strobes high, no ack.
REQ-034 ARB_LOCK_EN defined, dbg_lock=1, both requesters held -> DBG granted repeatedly; the CPU is granted only after dbg_lock=0.
REQ-035 WAIT_CYCLES=0 read -> Mem_OE low 1 cycle; ack 3 cycles after the request.
